// File: rtl/uart_imem_loader.sv
// Assembles little-endian instruction words from UART bytes and writes them to instruction memory.
// Optional inter-byte timeout is enabled by defining LOADER_TIMEOUT_EN.
module uart_imem_loader #(
  parameter int unsigned WORD_BYTES     = 4,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned END_WORDS      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    load_en,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  input  logic                    rx_break,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_wdata,
  output logic                    write_done,
  output logic                    full,
  output logic                    busy
);

  localparam int unsigned WordW = 8 * WORD_BYTES;
  localparam logic [ADDR_W-1:0] AddrOne = 1;

  typedef enum logic [1:0] {StIdle, StAssemble, StWrite, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        idx_q;
  logic [3:0]        sent_q;
  logic [WordW-1:0]  word_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [WordW-1:0]  mem_wdata_q;
  logic              write_done_q;
  logic              full_q;
  logic              busy_q;
`ifdef LOADER_TIMEOUT_EN
  logic [31:0]       tmo_q;
`endif

  logic [WordW-1:0] word_ins;
  logic [WordW-1:0] word_b0;
  logic             last_byte;
  logic [3:0]       sent_d;
  logic             addr_last;
  logic             wr_end;
  logic             byte_ok;

  always_comb begin
    word_ins = word_q;
    for (int unsigned b = 0; b < WORD_BYTES; b++) begin
      if (idx_q == b[3:0]) word_ins[8*b +: 8] = rx_data;
    end
    word_b0       = word_q;
    word_b0[7:0]  = rx_data;
    last_byte     = (idx_q == 4'(WORD_BYTES - 1));
    // mem_wdata_q/mem_addr_q hold the word being written while in StWrite
    sent_d        = (&mem_wdata_q) ? sent_q + 4'd1 : 4'd0;
    addr_last     = &mem_addr_q;
    wr_end        = (sent_d == 4'(END_WORDS)) || addr_last;
    byte_ok       = rx_valid && !rx_break;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      idx_q        <= '0;
      sent_q       <= '0;
      word_q       <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      write_done_q <= 1'b0;
      full_q       <= 1'b0;
      busy_q       <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load_en) begin
            state_q <= StAssemble;
            addr_q  <= '0;
            idx_q   <= '0;
            sent_q  <= '0;
            full_q  <= 1'b0;
            busy_q  <= 1'b1;
`ifdef LOADER_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
        end
        StAssemble: begin
          if (!load_en) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            idx_q   <= '0;
          end else if (rx_break) begin
            idx_q <= '0;
`ifdef LOADER_TIMEOUT_EN
            tmo_q <= '0;
`endif
          end else if (rx_valid) begin
            word_q <= word_ins;
`ifdef LOADER_TIMEOUT_EN
            tmo_q  <= '0;
`endif
            if (last_byte) begin
              state_q     <= StWrite;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= addr_q;
              mem_wdata_q <= word_ins;
              idx_q       <= '0;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
`ifdef LOADER_TIMEOUT_EN
          else if (idx_q != 4'd0) begin
            if (tmo_q == TIMEOUT_CYCLES - 1) begin
              idx_q <= '0;
              tmo_q <= '0;
            end else begin
              tmo_q <= tmo_q + 32'd1;
            end
          end
`endif
        end
        StWrite: begin
          addr_q <= addr_q + AddrOne;
          sent_q <= sent_d;
          if (!load_en) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            idx_q   <= '0;
          end else if (wr_end) begin
            state_q      <= StDone;
            write_done_q <= 1'b1;
            full_q       <= addr_last;
            busy_q       <= 1'b0;
          end else if (byte_ok) begin
            // A byte arriving during the write opens the next word
            word_q <= word_b0;
`ifdef LOADER_TIMEOUT_EN
            tmo_q  <= '0;
`endif
            if (WORD_BYTES == 1) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= addr_q + AddrOne;
              mem_wdata_q <= word_b0;
              idx_q       <= '0;
            end else begin
              state_q <= StAssemble;
              idx_q   <= 4'd1;
            end
          end else begin
            state_q <= StAssemble;
          end
        end
        StDone: begin
          if (!load_en) begin
            state_q      <= StIdle;
            write_done_q <= 1'b0;
            full_q       <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign write_done = write_done_q;
  assign full       = full_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench: directed vector table, hand sequences and a randomized run against
// a byte-queue reference model of the loader.
module tb_uart_imem_loader;

  logic       clk = 1'b0;
  logic       resetn;
  logic       load_a, load_b;
  logic       rx_valid, rx_break;
  logic [7:0] rx_data;

  logic        we_a, done_a, full_a, busy_a;
  logic [7:0]  addr_a;
  logic [31:0] wd_a;
  logic        we_b, done_b, full_b, busy_b;
  logic [1:0]  addr_b;
  logic [31:0] wd_b;

  always #5 clk = ~clk;

  uart_imem_loader #(.TIMEOUT_CYCLES(100)) dut_a (
    .clk(clk), .resetn(resetn), .load_en(load_a), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_break(rx_break), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a),
    .write_done(done_a), .full(full_a), .busy(busy_a)
  );

  uart_imem_loader #(.ADDR_W(2), .TIMEOUT_CYCLES(100)) dut_b (
    .clk(clk), .resetn(resetn), .load_en(load_b), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_break(rx_break), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b),
    .write_done(done_b), .full(full_b), .busy(busy_b)
  );

  typedef struct packed {logic [7:0] addr; logic [31:0] data;} wr_t;
  wr_t wa_q[$];
  wr_t wb_q[$];

  always @(negedge clk) begin
    if (we_a) wa_q.push_back({addr_a, wd_a});
    if (we_b) wb_q.push_back({6'b0, addr_b, wd_b});
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic restart_a();
    load_a = 1'b0;
    tick();
    tick();
    wa_q.delete();
    load_a = 1'b1;
    tick();
  endtask

  // Reference model: bytes collect into a word; a complete word is a write.
  logic [7:0] rb[$];
  wr_t        exp_q[$];
  int         ref_addr, ref_sent;
  bit         ref_done;

  task automatic ref_reset();
    rb.delete();
    exp_q.delete();
    ref_addr = 0;
    ref_sent = 0;
    ref_done = 1'b0;
  endtask

  task automatic ref_byte(input logic [7:0] b);
    logic [31:0] w;
    if (ref_done) return;
    rb.push_back(b);
    if (rb.size() == 4) begin
      w = {rb[3], rb[2], rb[1], rb[0]};
      exp_q.push_back({8'(ref_addr), w});
      ref_sent = (w == 32'hFFFF_FFFF) ? ref_sent + 1 : 0;
      if (ref_sent == 2 || ref_addr == 255) ref_done = 1'b1;
      ref_addr++;
      rb.delete();
    end
  endtask

  task automatic ref_break();
    if (!ref_done) rb.delete();
  endtask

  typedef struct {
    bit          restart;
    logic [31:0] word;
    logic [7:0]  exp_addr;
    bit          exp_done;
    bit          exp_busy;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int n0;
    logic [31:0] exp_w;
    vecs[0] = '{1'b1, 32'hD000_0737, 8'd0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 32'h0000_0013, 8'd0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF, 8'd1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 32'hFFFF_FFFF, 8'd2, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 8'd0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 32'h0000_0013, 8'd1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF, 8'd2, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 32'h1234_5678, 8'd3, 1'b0, 1'b1};

    resetn = 1'b0; load_a = 1'b1; load_b = 1'b0;
    rx_valid = 1'b0; rx_break = 1'b0; rx_data = 8'h00;
    repeat (3) tick();
    check("rst_we", we_a, 0);
    check("rst_addr", addr_a, 0);
    check("rst_wdata", wd_a, 0);
    check("rst_done", done_a, 0);
    check("rst_full", full_a, 0);
    check("rst_busy", busy_a, 0);
    load_a = 1'b0;
    resetn = 1'b1;
    tick();

    // Directed table: each word lands one cycle after its last byte
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].restart) restart_a();
      send_word(vecs[v].word);
      check($sformatf("v%0d_we", v), we_a, 1);
      check($sformatf("v%0d_addr", v), addr_a, vecs[v].exp_addr);
      check($sformatf("v%0d_wdata", v), wd_a, vecs[v].word);
      tick();
      check($sformatf("v%0d_we_off", v), we_a, 0);
      check($sformatf("v%0d_done", v), done_a, vecs[v].exp_done);
      check($sformatf("v%0d_busy", v), busy_a, vecs[v].exp_busy);
    end

    // Bytes after the sentinel terminator are ignored
    restart_a();
    send_word(32'hFFFF_FFFF);
    send_word(32'hFFFF_FFFF);
    tick();
    send_word(32'hDEAD_BEEF);
    tick();
    check("post_done_writes", wa_q.size(), 2);
    check("post_done_flag", done_a, 1);
    check("post_done_wdata", wd_a, 32'hFFFF_FFFF);
    load_a = 1'b0;
    tick();
    check("done_clear", done_a, 0);

    // Break discards the partial word
    restart_a();
    send_byte(8'h11);
    send_byte(8'h22);
    rx_break = 1'b1; tick(); rx_break = 1'b0;
    send_word(32'h00F0_0793);
    tick();
    check("brk_writes", wa_q.size(), 1);
    if (wa_q.size() >= 1) begin
      check("brk_addr", wa_q[0].addr, 0);
      check("brk_wdata", wa_q[0].data, 32'h00F0_0793);
    end

    // load_en drop mid-word aborts and the next load restarts at address 0
    restart_a();
    send_word(32'h0000_0001);
    send_byte(8'h55);
    load_a = 1'b0; tick();
    check("abort_busy", busy_a, 0);
    load_a = 1'b1; tick();
    send_word(32'hA5A5_0002);
    tick();
    check("abort_writes", wa_q.size(), 2);
    if (wa_q.size() >= 2) begin
      check("abort_addr", wa_q[1].addr, 0);
      check("abort_wdata", wa_q[1].data, 32'hA5A5_0002);
    end

    // load_en drop during the write cycle: the write still happens once
    restart_a();
    send_word(32'h0BAD_F00D);
    load_a = 1'b0;
    check("wr_abort_we", we_a, 1);
    tick();
    check("wr_abort_busy", busy_a, 0);
    check("wr_abort_writes", wa_q.size(), 1);

    // Reset mid-word discards partial bytes and produces no write
    restart_a();
    send_byte(8'h77);
    send_byte(8'h88);
    resetn = 1'b0;
    #1;
    check("rstmid_busy", busy_a, 0);
    tick();
    resetn = 1'b1;
    tick(); tick();
    check("rstmid_nowrite", wa_q.size(), 0);
    send_word(32'h0000_0013);
    tick();
    check("rstmid_writes", wa_q.size(), 1);
    if (wa_q.size() >= 1) check("rstmid_wdata", wa_q[0].data, 32'h0000_0013);
    load_a = 1'b0;
    tick(); tick();

    // Small memory fills up and terminates with full
    wb_q.delete();
    load_b = 1'b1; tick();
    for (int k = 0; k < 4; k++) send_word(32'h100 + k);
    tick();
    check("full_writes", wb_q.size(), 4);
    for (int k = 0; k < 4 && k < wb_q.size(); k++)
      check($sformatf("full_addr%0d", k), wb_q[k].addr, k);
    check("full_flag", full_b, 1);
    check("full_done", done_b, 1);
    send_word(32'h0000_0104);
    tick();
    check("full_ignored", wb_q.size(), 4);
    load_b = 1'b0; tick();
    check("full_clear", full_b, 0);

    // Inter-byte timeout (only discards with LOADER_TIMEOUT_EN)
    restart_a();
    send_byte(8'hAA);
    repeat (150) tick();
    send_word(32'h0000_0013);
    tick();
`ifdef LOADER_TIMEOUT_EN
    exp_w = 32'h0000_0013;
`else
    exp_w = 32'h0000_13AA;
`endif
    check("tmo_writes", wa_q.size(), 1);
    if (wa_q.size() >= 1) check("tmo_wdata", wa_q[0].data, exp_w);

    // Randomized traffic against the reference model
    for (int r = 0; r < 4; r++) begin
      restart_a();
      ref_reset();
      for (int e = 0; e < 120; e++) begin
        int sel;
        sel = $urandom_range(0, 99);
        if (sel < 8) begin
          for (int i = 0; i < 4; i++) begin
            send_byte(8'hFF);
            ref_byte(8'hFF);
          end
        end else if (sel < 12) begin
          rx_break = 1'b1;
          rx_valid = ($urandom_range(0, 1) == 1);
          rx_data  = 8'($urandom);
          tick();
          rx_break = 1'b0;
          rx_valid = 1'b0;
          ref_break();
        end else begin
          logic [7:0] b;
          b = ($urandom_range(0, 9) < 3) ? 8'hFF : 8'($urandom);
          send_byte(b);
          ref_byte(b);
        end
        repeat ($urandom_range(0, 2)) tick();
      end
      tick(); tick();
      n0 = wa_q.size();
      check($sformatf("rnd%0d_count", r), n0, exp_q.size());
      for (int i = 0; i < n0 && i < exp_q.size(); i++)
        check($sformatf("rnd%0d_wr%0d", r, i), wa_q[i], exp_q[i]);
      check($sformatf("rnd%0d_done", r), done_a, ref_done);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_imem_loader.md
UART_IMEM_LOADER -- requirements
Module: uart_imem_loader

Interface
REQ-001 SHALL have parameter WORD_BYTES, default 4: bytes per assembled instruction word (1..8).
REQ-002 SHALL have parameter ADDR_W, default 8: memory word-address width; depth = 2^ADDR_W.
REQ-003 SHALL have parameter END_WORDS, default 2: number of consecutive all-ones words that terminates a load (1..15).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 65535: inter-byte timeout in clk cycles (used only with LOADER_TIMEOUT_EN).
REQ-005 SHALL have port clk  input  1  single system clock, all logic rising-edge.
REQ-006 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port load_en  input  1  level enable; high = loading permitted.
REQ-008 SHALL have port rx_valid  input  1  one-cycle strobe, received byte present on rx_data.
REQ-009 SHALL have port rx_data  input  8  received UART byte.
REQ-010 SHALL have port rx_break  input  1  one-cycle strobe, UART BREAK detected.
REQ-011 SHALL have port mem_we  output  1  one-cycle instruction-memory write strobe.
REQ-012 SHALL have port mem_addr  output  ADDR_W  word address of the write.
REQ-013 SHALL have port mem_wdata  output  8*WORD_BYTES  assembled word.
REQ-014 SHALL have port write_done  output  1  load complete (sentinel or full).
REQ-015 SHALL have port full  output  1  load ended because last address was written.
REQ-016 SHALL have port busy  output  1  high in ASSEMBLE or WRITE.

Function
REQ-017 SHALL implement states IDLE, ASSEMBLE, WRITE, DONE.
REQ-018 IDLE -> ASSEMBLE when load_en=1; on entry: address counter=0, byte index=0, sentinel count=0, full=0.
REQ-019 ASSEMBLE: each rx_valid byte SHALL be stored little-endian (first byte -> bits [7:0]); byte index increments.
REQ-020 Acceptance of byte WORD_BYTES-1 SHALL move to WRITE on the next cycle; latency last rx_valid -> mem_we = 1 cycle.
REQ-021 WRITE: mem_we=1 for exactly one cycle with mem_addr=address counter and mem_wdata=assembled word; address counter increments after the write.
REQ-022 Sentinel words (all bits 1) SHALL be written like any other word; sentinel count increments on an all-ones word and clears on any other word.
REQ-023 WRITE -> DONE when sentinel count reaches END_WORDS, or when address 2^ADDR_W-1 was just written (full=1); otherwise WRITE -> ASSEMBLE.
REQ-024 rx_valid coincident with WRITE SHALL be accepted as byte 0 of the next word unless WRITE -> DONE, in which case it is dropped.
REQ-025 rx_break in ASSEMBLE SHALL discard the partial word (byte index=0) without a write; address and sentinel count unchanged.
REQ-026 rx_break coincident with rx_valid: break wins, byte dropped.
REQ-027 load_en=0 in ASSEMBLE or WRITE SHALL abort to IDLE next cycle; a WRITE in progress that same cycle still completes its single mem_we.
REQ-028 DONE: write_done=1, all rx_valid ignored, mem_we=0; DONE -> IDLE when load_en=0, clearing write_done and full.
REQ-029 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.

Reset
REQ-030 resetn=0 SHALL asynchronously force IDLE, mem_we=0, mem_addr=0, mem_wdata=0, write_done=0, full=0, busy=0, all counters 0.
REQ-031 Reset mid-word SHALL discard the partial word; no write occurs on reset release.

Configuration
REQ-032 Macro LOADER_TIMEOUT_EN defined: in ASSEMBLE with byte index>0, TIMEOUT_CYCLES cycles without rx_valid SHALL discard the partial word (as REQ-025).
REQ-033 LOADER_TIMEOUT_EN undefined: no timeout counter; partial words persist indefinitely.

Verification
REQ-034 Defaults, load_en=1, bytes 37 07 00 D0 -> one mem_we, mem_addr=0, mem_wdata=32'hD0000737, 1 cycle after last byte.
REQ-035 Defaults, words 00000013, FFFFFFFF, FFFFFFFF -> writes at addr 0,1,2; write_done=1 after third write; later bytes produce no mem_we.
REQ-036 Defaults, FFFFFFFF, 00000013, FFFFFFFF -> no termination; sentinel count reset by middle word; busy stays 1.
REQ-037 ADDR_W=2, four non-sentinel words -> writes at 0..3, full=1, write_done=1; fifth word ignored.
REQ-038 Bytes 11 22, rx_break, then 93 07 F0 00 -> single write mem_wdata=32'h00F00793 at addr 0.
REQ-039 With LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=100: byte AA, 150 idle cycles, then 13 00 00 00 -> single write 32'h00000013; without macro -> write 32'h000013AA.
